vx_issue_scoreboard: RTL and testbench



---
 rtl/vx_issue_scoreboard.sv | 169 ++++++++++++++++
 tb/tb_vx_issue_scoreboard.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : vx_issue_scoreboard
// Brief    : Per-warp register scoreboard for one issue slice. Stalls any
//            instruction whose rd or enabled sources have an in-flight write
//            in the same warp, releases registers from the commit writeback
//            stream (with same-cycle bypass), and hands accepted
//            instructions downstream through a one-entry output register.
//            Also counts hazard stalls and flags a sticky timeout.
// Revision : 1.0 - initial release
// ============================================================================
module vx_issue_scoreboard #(
  parameter int NUM_WARPS = 4,
  parameter int NUM_REGS  = 64,
  parameter int PAYLOAD_W = 64,
  parameter int TIMEOUT   = 4096,
  parameter int CTR_W     = 44,
  localparam int WID_W    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int RID_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  // instruction in
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WID_W-1:0]     in_wid,
  input  logic                 in_wb,
  input  logic [RID_W-1:0]     in_rd,
  input  logic [RID_W-1:0]     in_rs1,
  input  logic [RID_W-1:0]     in_rs2,
  input  logic [RID_W-1:0]     in_rs3,
  input  logic [2:0]           in_rs_used,
  input  logic [PAYLOAD_W-1:0] in_payload,
  // instruction out
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WID_W-1:0]     out_wid,
  output logic [PAYLOAD_W-1:0] out_payload,
  // writeback release
  input  logic                 wb_valid,
  input  logic [WID_W-1:0]     wb_wid,
  input  logic [RID_W-1:0]     wb_rd,
  input  logic                 wb_eop,
  // status
  output logic [CTR_W-1:0]     stall_count,
  output logic                 timeout
);

  // Watchdog only has to count up to TIMEOUT, then it saturates.
  localparam int               WD_W       = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  c_wd_max   = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0]  c_wd_last  = WD_W'(TIMEOUT - 1);
  localparam logic [RID_W-1:0] c_reg_zero = '0;

  logic [NUM_WARPS-1:0][NUM_REGS-1:0] r_inuse;
  logic                 r_out_valid;
  logic [WID_W-1:0]     r_out_wid;
  logic [PAYLOAD_W-1:0] r_out_payload;
  logic [CTR_W-1:0]     r_stall_count;
  logic [WD_W-1:0]      r_watchdog;
  logic                 r_timeout;

  logic                 w_release;
  logic [NUM_REGS-1:0]  w_row_eff;
  logic                 w_hazard;
  logic                 w_out_stall;
  logic                 w_accept;
  logic                 w_set;
  logic                 w_stalling;

  assign w_release = wb_valid && wb_eop && (wb_rd != c_reg_zero);

  // Scoreboard row of the issuing warp with this cycle's release already applied.
  always_comb begin
    w_row_eff = r_inuse[in_wid];
    if (w_release && (wb_wid == in_wid)) begin
      w_row_eff[wb_rd] = 1'b0;
    end
  end

  // Register 0 never hazards, regardless of the scoreboard contents.
  assign w_hazard = (in_wb         && (in_rd  != c_reg_zero) && w_row_eff[in_rd])
                 || (in_rs_used[0] && (in_rs1 != c_reg_zero) && w_row_eff[in_rs1])
                 || (in_rs_used[1] && (in_rs2 != c_reg_zero) && w_row_eff[in_rs2])
                 || (in_rs_used[2] && (in_rs3 != c_reg_zero) && w_row_eff[in_rs3]);

  assign w_out_stall = r_out_valid && !out_ready;
  assign in_ready    = !w_hazard && !w_out_stall;
  assign w_accept    = in_valid && in_ready;
  assign w_set       = w_accept && in_wb && (in_rd != c_reg_zero);
  assign w_stalling  = in_valid && w_hazard;

  // Scoreboard update: release first, then set, so a same-cycle set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inuse <= '0;
    end else begin
      if (w_release) begin
        r_inuse[wb_wid][wb_rd] <= 1'b0;
      end
      if (w_set) begin
        r_inuse[in_wid][in_rd] <= 1'b1;
      end
    end
  end

  // One-entry output stage: load on accept, drain when downstream takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Output data carries no reset; it is only meaningful while out_valid is high.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_out_wid     <= in_wid;
      r_out_payload <= in_payload;
    end
  end

  // Free-running hazard stall counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (w_stalling) begin
      r_stall_count <= r_stall_count + CTR_W'(1);
    end
  end

  // Watchdog over consecutive stall cycles; timeout is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_watchdog <= '0;
      r_timeout  <= 1'b0;
    end else if (w_stalling) begin
      if (r_watchdog != c_wd_max) begin
        r_watchdog <= r_watchdog + WD_W'(1);
      end
      if (r_watchdog >= c_wd_last) begin
        r_timeout <= 1'b1;
      end
    end else begin
      r_watchdog <= '0;
    end
  end

`ifndef SYNTHESIS
  // A release of a register that holds no pending write points at a commit bug.
  always_ff @(posedge clk) begin
    if (!reset && w_release) begin
      assert (r_inuse[wb_wid][wb_rd])
        else $error("scoreboard release of idle register wid=%0d rd=%0d", wb_wid, wb_rd);
    end
  end
`endif

  assign out_valid   = r_out_valid;
  assign out_wid     = r_out_wid;
  assign out_payload = r_out_payload;
  assign stall_count = r_stall_count;
  assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_vx_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_issue_scoreboard
// Brief    : Directed self-checking bench for vx_issue_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vx_issue_scoreboard;

  localparam int NUM_WARPS = 4;
  localparam int NUM_REGS  = 64;
  localparam int PAYLOAD_W = 64;
  localparam int TIMEOUT   = 16;
  localparam int CTR_W     = 44;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           in_wid;
  logic                 in_wb;
  logic [5:0]           in_rd, in_rs1, in_rs2, in_rs3;
  logic [2:0]           in_rs_used;
  logic [PAYLOAD_W-1:0] in_payload;
  logic                 out_valid;
  logic                 out_ready;
  logic [1:0]           out_wid;
  logic [PAYLOAD_W-1:0] out_payload;
  logic                 wb_valid;
  logic [1:0]           wb_wid;
  logic [5:0]           wb_rd;
  logic                 wb_eop;
  logic [CTR_W-1:0]     stall_count;
  logic                 timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  vx_issue_scoreboard #(
    .NUM_WARPS (NUM_WARPS),
    .NUM_REGS  (NUM_REGS),
    .PAYLOAD_W (PAYLOAD_W),
    .TIMEOUT   (TIMEOUT),
    .CTR_W     (CTR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_wid      (in_wid),
    .in_wb       (in_wb),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_rs3      (in_rs3),
    .in_rs_used  (in_rs_used),
    .in_payload  (in_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_wid     (out_wid),
    .out_payload (out_payload),
    .wb_valid    (wb_valid),
    .wb_wid      (wb_wid),
    .wb_rd       (wb_rd),
    .wb_eop      (wb_eop),
    .stall_count (stall_count),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic idle_in();
    in_valid   = 1'b0;
    in_wid     = '0;
    in_wb      = 1'b0;
    in_rd      = '0;
    in_rs1     = '0;
    in_rs2     = '0;
    in_rs3     = '0;
    in_rs_used = '0;
    in_payload = '0;
  endtask

  task automatic idle_wb();
    wb_valid = 1'b0;
    wb_wid   = '0;
    wb_rd    = '0;
    wb_eop   = 1'b0;
  endtask

  task automatic issue(input logic [1:0] wid, input logic wb, input logic [5:0] rd,
                       input logic [5:0] rs1, input logic [2:0] used, input logic [63:0] pl);
    in_valid   = 1'b1;
    in_wid     = wid;
    in_wb      = wb;
    in_rd      = rd;
    in_rs1     = rs1;
    in_rs2     = '0;
    in_rs3     = '0;
    in_rs_used = used;
    in_payload = pl;
  endtask

  task automatic release_reg(input logic [1:0] wid, input logic [5:0] rd, input logic eop);
    wb_valid = 1'b1;
    wb_wid   = wid;
    wb_rd    = rd;
    wb_eop   = eop;
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    idle_in();
    idle_wb();
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("reset_out_valid",   64'(out_valid),   64'd0);
    chk("reset_stall_count", 64'(stall_count), 64'd0);
    chk("reset_timeout",     64'(timeout),     64'd0);
    chk("reset_in_ready",    64'(in_ready),    64'd1);

    // Producer wid=1 rd=5
    issue(2'd1, 1'b1, 6'd5, 6'd0, 3'b000, 64'hA0A0);
    #1;
    chk("prod_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("prod_out_valid",   64'(out_valid),   64'd1);
    chk("prod_out_wid",     64'(out_wid),     64'd1);
    chk("prod_out_payload", out_payload,      64'hA0A0);

    // Consumer of wid=1 r5 stalls two cycles
    issue(2'd1, 1'b0, 6'd0, 6'd5, 3'b001, 64'hB0B0);
    #1;
    chk("raw_blocked", 64'(in_ready), 64'd0);
    tick();
    chk("stall_cnt_1",       64'(stall_count), 64'd1);
    chk("drain_out_valid",   64'(out_valid),   64'd0);
    tick();
    chk("stall_cnt_2",       64'(stall_count), 64'd2);

    // Same-cycle release bypass unblocks it
    release_reg(2'd1, 6'd5, 1'b1);
    #1;
    chk("bypass_ready", 64'(in_ready), 64'd1);
    tick();
    idle_wb();
    chk("bypass_out_payload", out_payload,      64'hB0B0);
    chk("bypass_stall_cnt",   64'(stall_count), 64'd2);

    // Warp isolation: wid=1 r5 in use, wid=2 reads r5
    issue(2'd1, 1'b1, 6'd5, 6'd0, 3'b000, 64'hC0C0);
    tick();
    issue(2'd2, 1'b0, 6'd0, 6'd5, 3'b001, 64'hD0D0);
    #1;
    chk("iso_ready", 64'(in_ready), 64'd1);
    tick();
    chk("iso_out_wid",     64'(out_wid), 64'd2);
    chk("iso_out_payload", out_payload,  64'hD0D0);

    // Writeback without eop does not release
    issue(2'd1, 1'b0, 6'd0, 6'd5, 3'b001, 64'hE0E0);
    release_reg(2'd1, 6'd5, 1'b0);
    #1;
    chk("noeop_blocked", 64'(in_ready), 64'd0);
    tick();
    chk("noeop_stall_cnt", 64'(stall_count), 64'd3);
    wb_eop = 1'b1;
    #1;
    chk("eop_ready", 64'(in_ready), 64'd1);
    tick();
    idle_wb();
    chk("eop_out_payload", out_payload,      64'hE0E0);
    chk("eop_stall_cnt",   64'(stall_count), 64'd3);

    // rd=0 never reserves; reading r0 never stalls
    issue(2'd0, 1'b1, 6'd0, 6'd0, 3'b000, 64'hF0F0);
    #1;
    chk("rd0_ready", 64'(in_ready), 64'd1);
    tick();
    issue(2'd0, 1'b0, 6'd0, 6'd0, 3'b111, 64'h1111);
    #1;
    chk("rs0_ready", 64'(in_ready), 64'd1);
    tick();
    chk("rs0_out_payload", out_payload, 64'h1111);

    // Backpressure holds the output and blocks issue
    out_ready = 1'b0;
    issue(2'd3, 1'b0, 6'd0, 6'd0, 3'b000, 64'h2222);
    #1;
    chk("bp_blocked", 64'(in_ready), 64'd0);
    tick();
    chk("bp_out_valid",   64'(out_valid), 64'd1);
    chk("bp_out_payload", out_payload,    64'h1111);
    chk("bp_stall_cnt",   64'(stall_count), 64'd3);
    idle_in();
    out_ready = 1'b1;
    tick();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Same-cycle set and release of wid=3 r7: set wins
    issue(2'd3, 1'b1, 6'd7, 6'd0, 3'b000, 64'h3333);
    tick();
    issue(2'd3, 1'b1, 6'd7, 6'd0, 3'b000, 64'h4444);
    release_reg(2'd3, 6'd7, 1'b1);
    #1;
    chk("setrel_ready", 64'(in_ready), 64'd1);
    tick();
    idle_wb();
    chk("setrel_out_payload", out_payload, 64'h4444);

    // Hold the hazard TIMEOUT cycles
    issue(2'd3, 1'b0, 6'd0, 6'd7, 3'b001, 64'h5555);
    #1;
    chk("setwins_blocked", 64'(in_ready), 64'd0);
    repeat (TIMEOUT - 1) tick();
    chk("timeout_not_yet", 64'(timeout), 64'd0);
    tick();
    chk("timeout_set",       64'(timeout),     64'd1);
    chk("timeout_stall_cnt", 64'(stall_count), 64'd19);
    release_reg(2'd3, 6'd7, 1'b1);
    #1;
    chk("timeout_rel_ready", 64'(in_ready), 64'd1);
    tick();
    idle_wb();
    idle_in();
    tick();
    chk("timeout_sticky", 64'(timeout), 64'd1);

    // Reset mid-operation
    issue(2'd0, 1'b1, 6'd9, 6'd0, 3'b000, 64'h6666);
    tick();
    idle_in();
    chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    chk("rst_out_valid",   64'(out_valid),   64'd0);
    chk("rst_timeout",     64'(timeout),     64'd0);
    chk("rst_stall_count", 64'(stall_count), 64'd0);
    issue(2'd0, 1'b0, 6'd0, 6'd9, 3'b001, 64'h7777);
    #1;
    chk("rst_inuse_cleared", 64'(in_ready), 64'd1);
    tick();
    idle_in();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
